// File: rtl/tft_fb_reader.sv
// tft_fb_reader: AHB-Lite read master that streams one framebuffer frame of
// 32-bit pixel words into the downstream line FIFO. It uses fixed-length
// INCR bursts, and the remainder words go out as SINGLE transfers. A burst
// is only issued when the FIFO has room for the whole of it.
// Optional build macro: TFT_FB_DOUBLE_BUFFER_EN. When it is defined, FB_SEL
// chooses between BASE_ADDR and ALT_ADDR at FRAME_START.
module tft_fb_reader #(
  parameter logic [31:0] BASE_ADDR = 32'h0f000000,
  parameter logic [31:0] ALT_ADDR  = 32'h0f200000,
  parameter int          WIDTH     = 800,
  parameter int          HEIGHT    = 480,
  parameter int          BURST_LEN = 8,
  parameter int          SPACE_W   = 7
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               FRAME_START,
  input  logic               FB_SEL,
  input  logic [SPACE_W-1:0] FIFO_SPACE,
  output logic               FIFO_WR,
  output logic [31:0]        FIFO_DATA,
  output logic [31:0]        HADDR,
  output logic [2:0]         HBURST,
  output logic [1:0]         HTRANS,
  output logic               HWRITE,
  output logic [31:0]        HWDATA,
  input  logic [31:0]        HRDATA,
  input  logic               HREADY,
  input  logic               HRESP,
  output logic               BUSY_OUT,
  output logic               DONE_OUT,
  output logic               ERROR_OUT,
  output logic               OVERRUN_OUT
);

  localparam int N  = WIDTH * HEIGHT;
  // Sized so that both N and BURST_LEN always fit.
  localparam int CW = $clog2(N + BURST_LEN + 1);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [CW-1:0] N_C         = CW'(N);
  localparam logic [CW-1:0] BL_C        = CW'(BURST_LEN);
  localparam logic [31:0]   BURST_BYTES = 32'(BURST_LEN * 4);
  localparam logic [2:0]    B_SINGLE    = 3'b000;
  localparam logic [2:0]    B_INCR      = (BURST_LEN == 4) ? 3'b011 : 3'b101;
  localparam logic [1:0]    T_IDLE      = 2'b00;
  localparam logic [1:0]    T_NONSEQ    = 2'b10;
  localparam logic [1:0]    T_SEQ       = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ADDR, S_DATA, S_FIN, S_ERR} state_t;

  state_t        state;
  logic [31:0]   fetch_addr;    // start address of the next burst
  logic [31:0]   restart_base;  // base captured by a FRAME_START that arrives while busy
  logic          restart;
  logic [CW-1:0] word_cnt;      // words issued so far in this frame
  logic [BW-1:0] beats_left;    // address phases still to go after the current one
  logic          dphase;        // an AHB data phase is in progress this cycle

  logic [31:0]   sel_base;
  logic [CW-1:0] remaining;
  logic          use_burst;
  logic [CW-1:0] cur_len;
  logic [31:0]   space_ext;
  logic          space_ok;
  logic          beat_done;
  logic          beat_err;

`ifdef TFT_FB_DOUBLE_BUFFER_EN
  assign sel_base = FB_SEL ? ALT_ADDR : BASE_ADDR;
`else
  assign sel_base = BASE_ADDR;
  logic unused_sel;
  assign unused_sel = ^{FB_SEL, ALT_ADDR};
`endif

  assign HWRITE    = 1'b0;
  assign HWDATA    = '0;

  assign remaining = N_C - word_cnt;
  assign use_burst = (remaining >= BL_C);
  assign cur_len   = use_burst ? BL_C : CW'(1);
  assign space_ext = 32'(FIFO_SPACE);
  assign space_ok  = use_burst ? (space_ext >= 32'(BURST_LEN)) : (space_ext != 32'd0);
  // A data phase completes on HREADY. An error is taken on its first cycle,
  // which is the cycle where HRESP is high and HREADY is still low.
  assign beat_done = dphase & HREADY & ~HRESP;
  assign beat_err  = dphase & ~HREADY & HRESP;

  // Data capture: one FIFO write per completed beat, and track the data phase.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      FIFO_WR   <= 1'b0;
      FIFO_DATA <= '0;
      dphase    <= 1'b0;
    end else begin
      FIFO_WR <= beat_done;
      if (beat_done) FIFO_DATA <= HRDATA;
      if (beat_err)    dphase <= 1'b0;
      else if (HREADY) dphase <= HTRANS[1];
    end
  end

  // Fetch FSM: paces bursts on FIFO space, drives the AHB address phase, and
  // handles restart, error and end of frame.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state        <= S_IDLE;
      HADDR        <= '0;
      HTRANS       <= T_IDLE;
      HBURST       <= B_SINGLE;
      BUSY_OUT     <= 1'b0;
      DONE_OUT     <= 1'b0;
      ERROR_OUT    <= 1'b0;
      OVERRUN_OUT  <= 1'b0;
      fetch_addr   <= '0;
      restart_base <= '0;
      restart      <= 1'b0;
      word_cnt     <= '0;
      beats_left   <= '0;
    end else begin
      DONE_OUT    <= 1'b0;
      OVERRUN_OUT <= FRAME_START && (state == S_WAIT || state == S_ADDR || state == S_DATA);
      if (beat_err && (state == S_ADDR || state == S_DATA)) begin
        // Abandon the burst at once. Any pending restart is dropped as well.
        HTRANS    <= T_IDLE;
        ERROR_OUT <= 1'b1;
        restart   <= 1'b0;
        state     <= S_ERR;
      end else begin
        case (state)
          S_IDLE: begin
            if (FRAME_START) begin
              fetch_addr <= sel_base;
              word_cnt   <= '0;
              restart    <= 1'b0;
              ERROR_OUT  <= 1'b0;
              BUSY_OUT   <= 1'b1;
              state      <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (FRAME_START) begin
              // No burst is in flight here, so the restart takes effect at once.
              fetch_addr <= sel_base;
              word_cnt   <= '0;
            end else if (!dphase && space_ok) begin
              HADDR      <= fetch_addr;
              HTRANS     <= T_NONSEQ;
              HBURST     <= use_burst ? B_INCR : B_SINGLE;
              beats_left <= use_burst ? BW'(BURST_LEN - 1) : '0;
              fetch_addr <= fetch_addr + (use_burst ? BURST_BYTES : 32'd4);
              word_cnt   <= word_cnt + cur_len;
              state      <= S_ADDR;
            end
          end
          S_ADDR: begin
            if (FRAME_START) begin
              restart      <= 1'b1;
              restart_base <= sel_base;
            end
            if (HREADY) begin
              if (beats_left == '0) begin
                HTRANS <= T_IDLE;
                state  <= S_DATA;
              end else begin
                HADDR      <= HADDR + 32'd4;
                HTRANS     <= T_SEQ;
                beats_left <= beats_left - 1'b1;
              end
            end
          end
          S_DATA: begin
            if (beat_done) begin
              if (FRAME_START || restart) begin
                fetch_addr <= FRAME_START ? sel_base : restart_base;
                word_cnt   <= '0;
                restart    <= 1'b0;
                state      <= S_WAIT;
              end else if (word_cnt == N_C) begin
                state <= S_FIN;
              end else begin
                state <= S_WAIT;
              end
            end else if (FRAME_START) begin
              restart      <= 1'b1;
              restart_base <= sel_base;
            end
          end
          S_FIN, S_ERR: begin
            DONE_OUT <= (state == S_FIN);
            if (FRAME_START) begin
              fetch_addr <= sel_base;
              word_cnt   <= '0;
              ERROR_OUT  <= 1'b0;
              state      <= S_WAIT;
            end else begin
              BUSY_OUT <= 1'b0;
              state    <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tft_fb_reader.sv
// Bench for tft_fb_reader with a 5x2 frame (one INCR8 plus two SINGLEs).
// It contains an AHB slave whose read data is a hash of the address. The
// reference model works per frame: word i of the frame comes from base+4*i.
// Each FIFO write must follow a completed bus beat by exactly one cycle.
module tb_tft_fb_reader;
  localparam int W    = 5;
  localparam int H    = 2;
  localparam int BL   = 8;
  localparam int N    = W * H;
  localparam int FULL = (N / BL) * BL;
  localparam logic [31:0] BASE = 32'h0f000000;
  localparam logic [31:0] ALT  = 32'h0f200000;

  logic        HCLK, HRESETn, FRAME_START, FB_SEL;
  logic [6:0]  FIFO_SPACE;
  logic        FIFO_WR;
  logic [31:0] FIFO_DATA, HADDR, HWDATA, HRDATA;
  logic [2:0]  HBURST;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic        BUSY_OUT, DONE_OUT, ERROR_OUT, OVERRUN_OUT;

  int checks = 0;
  int errors = 0;
  logic [31:0] seed;
  logic        mon_en, rnd;
  logic [31:0] mbase;
  int          a_idx, w_idx, n_wr, n_done, n_ovr, n_act;
  logic        done_busy;
  logic        exp_wr, dph;
  logic [31:0] dph_addr;
  logic [1:0]  prev_trans;
  logic [6:0]  prev_space;

  tft_fb_reader #(.BASE_ADDR(BASE), .ALT_ADDR(ALT), .WIDTH(W), .HEIGHT(H),
                  .BURST_LEN(BL), .SPACE_W(7)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .FRAME_START(FRAME_START), .FB_SEL(FB_SEL),
    .FIFO_SPACE(FIFO_SPACE), .FIFO_WR(FIFO_WR), .FIFO_DATA(FIFO_DATA),
    .HADDR(HADDR), .HBURST(HBURST), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .BUSY_OUT(BUSY_OUT), .DONE_OUT(DONE_OUT), .ERROR_OUT(ERROR_OUT),
    .OVERRUN_OUT(OVERRUN_OUT)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ seed;
  endfunction

  function automatic logic [31:0] base_of(input logic sel);
`ifdef TFT_FB_DOUBLE_BUFFER_EN
    return sel ? ALT : BASE;
`else
    return (sel === 1'bx) ? 32'hx : BASE;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample and check at the negedge, then drive the slave just after the posedge.
  task automatic step();
    int need;
    @(negedge HCLK);
    chk("fifo_wr", 32'(FIFO_WR), 32'(exp_wr));
    if (FIFO_WR) begin
      if (mon_en) chk("fifo_data", FIFO_DATA, mem(mbase + 32'(4 * w_idx)));
      w_idx++;
      n_wr++;
    end
    if (DONE_OUT) begin n_done++; done_busy = BUSY_OUT; end
    if (OVERRUN_OUT) n_ovr++;
    if (HTRANS != 2'b00) n_act++;
    need = (a_idx < FULL) ? BL : 1;
    if (mon_en && HTRANS == 2'b10 && prev_trans == 2'b00)
      chk("space_paced", 32'(int'(prev_space) >= need), 32'd1);
    if (mon_en && HRESETn && HREADY && HTRANS[1]) begin
      chk("haddr", HADDR, mbase + 32'(4 * a_idx));
      chk("hburst", 32'(HBURST), (a_idx < FULL) ? 32'd5 : 32'd0);
      chk("htrans", 32'(HTRANS), (a_idx >= FULL || a_idx % BL == 0) ? 32'd2 : 32'd3);
      a_idx++;
    end
    if (!HRESETn) begin exp_wr = 1'b0; dph = 1'b0; end
    else if (HREADY) begin
      exp_wr   = dph && !HRESP;
      dph      = HTRANS[1];
      dph_addr = HADDR;
    end else exp_wr = 1'b0;
    prev_trans = HTRANS;
    prev_space = FIFO_SPACE;
    @(posedge HCLK);
    #1;
    if (rnd) begin
      HREADY     = ($urandom_range(3) != 0);
      FIFO_SPACE = 7'($urandom_range(40));
    end
    HRDATA = dph ? mem(dph_addr) : 32'hdeadbeef;
  endtask

  task automatic arm(input logic [31:0] b);
    mbase = b; a_idx = 0; w_idx = 0; n_wr = 0; n_done = 0; n_ovr = 0; mon_en = 1'b1;
  endtask

  task automatic start_frame(input logic sel);
    arm(base_of(sel));
    FB_SEL = sel;
    FRAME_START = 1'b1;
    step();
    FRAME_START = 1'b0;
    FB_SEL = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int k;
    k = 0;
    while (n_done == 0 && k < budget) begin step(); k++; end
    chk("done_seen", 32'(n_done), 32'd1);
  endtask

  initial begin
    seed = $urandom;
    HRESETn = 1'b0; FRAME_START = 1'b0; FB_SEL = 1'b0; FIFO_SPACE = 7'd64;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    mon_en = 1'b0; rnd = 1'b0; mbase = BASE; a_idx = 0; w_idx = 0;
    n_wr = 0; n_done = 0; n_ovr = 0; n_act = 0; done_busy = 1'b0;
    exp_wr = 1'b0; dph = 1'b0; dph_addr = '0; prev_trans = '0; prev_space = '0;
    @(posedge HCLK); #1;
    step(); step();
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_hburst", 32'(HBURST), 32'd0);
    chk("rst_haddr", HADDR, 32'd0);
    chk("rst_hwrite", 32'(HWRITE), 32'd0);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_fifo_data", FIFO_DATA, 32'd0);
    chk("rst_busy", 32'(BUSY_OUT), 32'd0);
    chk("rst_done", 32'(DONE_OUT), 32'd0);
    chk("rst_error", 32'(ERROR_OUT), 32'd0);
    chk("rst_overrun", 32'(OVERRUN_OUT), 32'd0);
    HRESETn = 1'b1;
    step();

    // Zero-wait frame: INCR8 from base, then two SINGLEs.
    start_frame(1'b0);
    chk("t1_busy", 32'(BUSY_OUT), 32'd1);
    chk("t1_idle_before", 32'(HTRANS), 32'd0);
    step();
    chk("t1_nonseq", 32'(HTRANS), 32'd2);
    chk("t1_first_addr", HADDR, BASE);
    chk("t1_incr8", 32'(HBURST), 32'd5);
    run_until_done(200);
    chk("t1_writes", 32'(n_wr), 32'(N));
    chk("t1_addrs", 32'(a_idx), 32'(N));
    chk("t1_busy_fall", 32'(done_busy), 32'd0);
    repeat (5) step();
    chk("t1_one_done", 32'(n_done), 32'd1);
    chk("t1_no_error", 32'(ERROR_OUT), 32'd0);

    // FIFO space one short of a burst: nothing is issued until it reaches 8.
    FIFO_SPACE = 7'd7;
    start_frame(1'b0);
    n_act = 0;
    repeat (20) step();
    chk("t3_no_issue", 32'(n_act), 32'd0);
    FIFO_SPACE = 7'd8;
    step();
    chk("t3_nonseq", 32'(HTRANS), 32'd2);
    run_until_done(200);
    chk("t3_writes", 32'(n_wr), 32'(N));
    FIFO_SPACE = 7'd64;
    step();

    // Three wait states on beat 4: the address phase holds and there are no extra writes.
    start_frame(1'b0);
    repeat (4) step();
    chk("t4_beat4_addr", HADDR, BASE + 32'd12);
    HREADY = 1'b0;
    repeat (3) begin
      step();
      chk("t4_hold_addr", HADDR, BASE + 32'd12);
      chk("t4_hold_trans", 32'(HTRANS), 32'd3);
    end
    HREADY = 1'b1;
    run_until_done(200);
    chk("t4_writes", 32'(n_wr), 32'(N));
    step();

    // Error on the beat 3 data phase.
    start_frame(1'b0);
    repeat (4) step();
    HREADY = 1'b0; HRESP = 1'b1;
    step();
    chk("t5_trans_idle", 32'(HTRANS), 32'd0);
    chk("t5_error_set", 32'(ERROR_OUT), 32'd1);
    HREADY = 1'b1;
    step();
    HRESP = 1'b0;
    repeat (6) step();
    chk("t5_two_writes", 32'(n_wr), 32'd2);
    chk("t5_no_done", 32'(n_done), 32'd0);
    chk("t5_not_busy", 32'(BUSY_OUT), 32'd0);
    chk("t5_error_sticky", 32'(ERROR_OUT), 32'd1);

    // Randomized wait states and FIFO space, FB_SEL=1; FRAME_START clears the error.
    rnd = 1'b1;
    start_frame(1'b1);
    chk("t5_error_cleared", 32'(ERROR_OUT), 32'd0);
    run_until_done(600);
    chk("rnd_writes", 32'(n_wr), 32'(N));
    chk("rnd_addrs", 32'(a_idx), 32'(N));
    rnd = 1'b0; HREADY = 1'b1; FIFO_SPACE = 7'd64;
    repeat (3) step();

    // FRAME_START mid-frame: overrun pulse, then a restart at the newly selected base.
    start_frame(1'b0);
    repeat (3) step();
    mon_en = 1'b0;
    FB_SEL = 1'b1; FRAME_START = 1'b1;
    step();
    FRAME_START = 1'b0; FB_SEL = 1'b0;
    chk("t6_overrun", 32'(OVERRUN_OUT), 32'd1);
    chk("t6_busy", 32'(BUSY_OUT), 32'd1);
    step();
    chk("t6_overrun_pulse", 32'(OVERRUN_OUT), 32'd0);
    begin
      int k;
      k = 0;
      while (HTRANS != 2'b10 && k < 50) begin step(); k++; end
    end
    chk("t6_restart_nonseq", 32'(HTRANS), 32'd2);
    chk("t6_restart_addr", HADDR, base_of(1'b1));
    chk("t6_restart_burst", 32'(HBURST), 32'd5);
    chk("t6_no_done_aborted", 32'(n_done), 32'd0);
    arm(base_of(1'b1));
    run_until_done(200);
    chk("t6_writes", 32'(n_wr), 32'(N));
    step();

    // Reset in the middle of a burst.
    start_frame(1'b0);
    repeat (3) step();
    HRESETn = 1'b0;
    step();
    chk("t7_htrans", 32'(HTRANS), 32'd0);
    chk("t7_haddr", HADDR, 32'd0);
    chk("t7_hburst", 32'(HBURST), 32'd0);
    chk("t7_busy", 32'(BUSY_OUT), 32'd0);
    chk("t7_fifo_wr", 32'(FIFO_WR), 32'd0);
    chk("t7_fifo_data", FIFO_DATA, 32'd0);
    HRESETn = 1'b1;
    n_act = 0; n_wr = 0;
    repeat (10) step();
    chk("t7_quiet_bus", 32'(n_act), 32'd0);
    chk("t7_no_writes", 32'(n_wr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
